// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared definitions for the SIPO frame controller slice.
//               Holds the default word width and the controller state
//               encoding.
// Contents    : SIPO_WIDTH     - default word length in bits
//               ST_IDLE/SHIFT  - explicit state encodings
//               state_e        - controller state type built on them
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  // Default word length; legal range for the controller is 2..64.
  localparam int SIPO_WIDTH = 32;

  // Explicit one-bit state encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_e;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_reg
// Description : WIDTH-bit serial-in / parallel-out shift register. Shifts
//               left by one with serial_in entering at bit 0 when shift_en
//               is high. A synchronous clear overrides the shift.
// Ports       : clock     - rising-edge clock
//               reset_n   - asynchronous active-low reset (register -> 0)
//               shift_en  - shift one bit in this cycle
//               clear     - synchronous clear, wins over shift_en
//               serial_in - incoming bit
//               sr        - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             serial_in,
  output logic [WIDTH-1:0] sr
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {sr[WIDTH-2:0], serial_in};
    end
  end

endmodule : sipo_shift_reg
`default_nettype wire

// File: rtl/sipo_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : sipo_frame_controller
// Description : Sequences a SIPO shift register to receive framed serial
//               data. Qualified bits are counted into WIDTH-bit words; each
//               completed word is offered on a valid/ready port. Detects
//               backpressure overruns (sticky) and discarded partial words
//               (one-cycle pulse).
// Ports       : clock        - rising-edge clock
//               reset_n      - asynchronous active-low reset
//               serial_in    - serial data, MSB of each word first
//               serial_valid - serial_in carries a bit this cycle
//               frame_start  - current bit is bit 0 of a new frame
//               frame_stop   - end of frame, partial word discarded
//               out_data     - completed word, first bit at MSB
//               out_valid    - out_data holds an unconsumed word
//               out_ready    - consumer accepts out_data
//               busy         - controller is in SHIFT
//               bit_count    - bits accumulated in the current word
//               partial_drop - pulse: non-empty partial word discarded
//               overrun      - sticky: completed word lost to backpressure
//               clear_err    - synchronous clear of overrun
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_controller
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             frame_start,
  input  logic             frame_stop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             partial_drop,
  output logic             overrun,
  input  logic             clear_err
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_e           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word_next;
  logic             sr_msb_unused;

  logic in_shift;
  logic stop_now;
  logic shift_en;
  logic has_partial;
  logic complete;
  logic take;
  logic overrun_evt;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  always_comb begin
    in_shift    = (state == SHIFT);
    // frame_start outranks a simultaneous frame_stop.
    stop_now    = in_shift & frame_stop & ~frame_start;
    // A start pulse accepts its own bit even from IDLE.
    shift_en    = serial_valid & (in_shift | frame_start);
    has_partial = (bit_count != '0);
    // A restart or stop on the final bit suppresses the word.
    complete    = in_shift & serial_valid & ~frame_start & ~frame_stop &
                  (bit_count == LAST_BIT);
    take        = out_valid & out_ready;
    // A slot frees up on the same edge it is consumed, so only a word
    // arriving against an unconsumed, non-accepted word is lost.
    overrun_evt = complete & out_valid & ~out_ready;
  end

  // The completed word includes the bit arriving on the completion edge,
  // which is what gives the single-cycle latency to out_valid.
  assign word_next     = {sr[WIDTH-2:0], serial_in};
  // The oldest register bit falls off the end when the word is captured.
  assign sr_msb_unused = sr[WIDTH-1];

  assign busy = in_shift;

  // --------------------------------------------------------------------------
  // Shift register datapath. Cleared on a stop so a later frame starts from
  // zero; on a restart the stale bits are simply shifted out before the next
  // completion, so no clear is needed there.
  // --------------------------------------------------------------------------
  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift_en  (shift_en),
    .clear     (stop_now),
    .serial_in (serial_in),
    .sr        (sr)
  );

  // --------------------------------------------------------------------------
  // State machine and bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_count    <= '0;
      partial_drop <= 1'b0;
    end else begin
      partial_drop <= 1'b0;
      if (frame_start) begin
        // Restart alignment from either state; in IDLE the count is already
        // zero, so no drop is reported there.
        state        <= SHIFT;
        bit_count    <= serial_valid ? ONE : '0;
        partial_drop <= has_partial;
      end else if (stop_now) begin
        state        <= IDLE;
        bit_count    <= '0;
        partial_drop <= has_partial;
      end else if (in_shift && serial_valid) begin
        // Wrap on completion so words stream back-to-back.
        bit_count <= (bit_count == LAST_BIT) ? '0 : bit_count + ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output port and overrun flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (complete && (!out_valid || out_ready)) begin
        out_data  <= word_next;
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (overrun_evt) begin
      // A new event beats a simultaneous clear.
      overrun <= 1'b1;
    end else if (clear_err) begin
      overrun <= 1'b0;
    end
  end

endmodule : sipo_frame_controller
`default_nettype wire

// File: tb/tb_sipo_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_frame_controller
// Description : Directed self-checking bench for sipo_frame_controller with
//               WIDTH = 32. Inputs change #1 after the rising edge; outputs
//               are checked in that same window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_frame_controller;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  logic             clock;
  logic             reset_n;
  logic             serial_in;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_stop;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             partial_drop;
  logic             overrun;
  logic             clear_err;

  int compared   = 0;
  int mismatched = 0;

  sipo_frame_controller #(
    .WIDTH (WIDTH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_stop   (frame_stop),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .bit_count    (bit_count),
    .partial_drop (partial_drop),
    .overrun      (overrun),
    .clear_err    (clear_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send bits w[hi] down to w[lo]; frame_start rides on the first one.
  // With gap set, each bit is followed by one idle cycle.
  task automatic send_range(input logic [31:0] w, input int hi, input int lo,
                            input bit start, input bit gap);
    for (int i = hi; i >= lo; i--) begin
      serial_in    = w[i];
      serial_valid = 1'b1;
      frame_start  = start && (i == hi);
      step();
      serial_valid = 1'b0;
      frame_start  = 1'b0;
      if (gap) step();
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    serial_in    = 1'b0;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    frame_stop   = 1'b0;
    out_ready    = 1'b0;
    clear_err    = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) step();
    check("rst_out_data",  out_data,     64'h0);
    check("rst_out_valid", out_valid,    64'h0);
    check("rst_busy",      busy,         64'h0);
    check("rst_bit_count", bit_count,    64'h0);
    check("rst_pdrop",     partial_drop, 64'h0);
    check("rst_overrun",   overrun,      64'h0);
    reset_n = 1'b1;
    step();

    // ---------------- single word, consumer ready ----------------
    out_ready = 1'b1;
    send_range(32'hA5A50F0F, 31, 1, 1'b1, 1'b0);
    check("w1_cnt_31",     bit_count, 64'd31);
    check("w1_no_valid",   out_valid, 64'h0);
    check("w1_busy",       busy,      64'h1);
    send_range(32'hA5A50F0F, 0, 0, 1'b0, 1'b0);
    check("w1_valid",      out_valid, 64'h1);
    check("w1_data",       out_data,  64'hA5A50F0F);
    check("w1_cnt_wrap",   bit_count, 64'h0);
    step();
    check("w1_valid_1cyc", out_valid, 64'h0);

    // ---------------- back-to-back words under backpressure ----------------
    out_ready = 1'b0;
    send_range(32'h12345678, 31, 0, 1'b1, 1'b0);
    check("bp_valid",      out_valid, 64'h1);
    check("bp_data1",      out_data,  64'h12345678);
    send_range(32'hDEADBEEF, 31, 0, 1'b0, 1'b0);
    check("bp_data_held",  out_data,  64'h12345678);
    check("bp_overrun",    overrun,   64'h1);
    check("bp_valid_held", out_valid, 64'h1);
    out_ready = 1'b1;
    step();
    check("bp_accepted",   out_valid, 64'h0);
    check("bp_ovr_sticky", overrun,   64'h1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("bp_ovr_clear",  overrun,   64'h0);

    // ---------------- accept and complete on the same edge ----------------
    out_ready = 1'b0;
    send_range(32'h0F0F0F0F, 31, 0, 1'b0, 1'b0);
    check("ac_first_valid", out_valid, 64'h1);
    send_range(32'h33CC33CC, 31, 1, 1'b0, 1'b0);
    out_ready = 1'b1;
    send_range(32'h33CC33CC, 0, 0, 1'b0, 1'b0);
    out_ready = 1'b0;
    check("ac_valid",      out_valid, 64'h1);
    check("ac_data",       out_data,  64'h33CC33CC);
    check("ac_no_overrun", overrun,   64'h0);
    // overrun set beats a simultaneous clear_err
    send_range(32'h55555555, 31, 1, 1'b0, 1'b0);
    clear_err = 1'b1;
    send_range(32'h55555555, 0, 0, 1'b0, 1'b0);
    clear_err = 1'b0;
    check("sw_overrun",    overrun,   64'h1);
    check("sw_data_held",  out_data,  64'h33CC33CC);
    out_ready = 1'b1;
    step();
    check("sw_accepted",   out_valid, 64'h0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("sw_ovr_clear",  overrun,   64'h0);

    // ---------------- partial word then frame_stop ----------------
    send_range(32'hC3C3C3C3, 31, 22, 1'b1, 1'b0);
    check("ps_cnt_10",     bit_count, 64'd10);
    frame_stop = 1'b1;
    step();
    frame_stop = 1'b0;
    check("ps_pdrop",      partial_drop, 64'h1);
    check("ps_idle",       busy,         64'h0);
    check("ps_cnt_0",      bit_count,    64'h0);
    check("ps_no_valid",   out_valid,    64'h0);
    step();
    check("ps_pdrop_end",  partial_drop, 64'h0);

    // ---------------- gapped serial_valid ----------------
    send_range(32'hFFFF0000, 31, 1, 1'b1, 1'b1);
    check("gap_cnt_31",    bit_count, 64'd31);
    check("gap_no_valid",  out_valid, 64'h0);
    send_range(32'hFFFF0000, 0, 0, 1'b0, 1'b0);
    check("gap_valid",     out_valid, 64'h1);
    check("gap_data",      out_data,  64'hFFFF0000);
    step();
    check("gap_consumed",  out_valid, 64'h0);

    // ---------------- asynchronous reset mid-word ----------------
    send_range(32'hCAFEBABE, 31, 12, 1'b1, 1'b0);
    check("ar_cnt_20",     bit_count, 64'd20);
    reset_n = 1'b0;
    #1;
    check("ar_out_data",   out_data,     64'h0);
    check("ar_bit_count",  bit_count,    64'h0);
    check("ar_busy",       busy,         64'h0);
    check("ar_pdrop",      partial_drop, 64'h0);
    check("ar_out_valid",  out_valid,    64'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("ar_pdrop_after", partial_drop, 64'h0);
    send_range(32'h000000FF, 31, 31, 1'b1, 1'b0);
    check("ar_start_nodrop", partial_drop, 64'h0);
    check("ar_start_cnt",    bit_count,    64'd1);
    send_range(32'h000000FF, 30, 0, 1'b0, 1'b0);
    check("ar_valid",      out_valid, 64'h1);
    check("ar_data",       out_data,  64'h000000FF);
    step();

    // ---------------- restart mid-word ----------------
    send_range(32'hFFFFFFFF, 31, 17, 1'b1, 1'b0);
    check("rs_cnt_15",     bit_count, 64'd15);
    send_range(32'h89ABCDEF, 31, 31, 1'b1, 1'b0);
    check("rs_pdrop",      partial_drop, 64'h1);
    check("rs_cnt_1",      bit_count,    64'd1);
    check("rs_no_valid",   out_valid,    64'h0);
    send_range(32'h89ABCDEF, 30, 0, 1'b0, 1'b0);
    check("rs_valid",      out_valid,    64'h1);
    check("rs_data",       out_data,     64'h89ABCDEF);
    check("rs_pdrop_end",  partial_drop, 64'h0);
    step();

    // ---------------- restart on the completion bit ----------------
    send_range(32'h5A5A5A5A, 31, 1, 1'b0, 1'b0);
    check("rc_cnt_31",     bit_count, 64'd31);
    send_range(32'h5A5A5A5A, 0, 0, 1'b1, 1'b0);
    check("rc_no_valid",   out_valid,    64'h0);
    check("rc_pdrop",      partial_drop, 64'h1);
    check("rc_cnt_1",      bit_count,    64'd1);
    frame_stop = 1'b1;
    step();
    frame_stop = 1'b0;
    check("rc_stop_pdrop", partial_drop, 64'h1);
    check("rc_stop_idle",  busy,         64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_sipo_frame_controller
`default_nettype wire
